// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the LCD panel-side receiver.
package lcd_rx_pkg;

  localparam int RX_XW = 11;
  localparam int RX_YW = 11;

  localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RX_OFF,
    RX_SYNC,
    RX_ACTIVE
  } rx_state_t;

  typedef struct packed {
    logic [23:0]      data;
    logic [RX_XW-1:0] x;
    logic [RX_YW-1:0] y;
    logic             sof;
  } rx_pix_t;

  function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [23:0] d);
    return {sig[30:0], sig[31]} ^ {8'h00, d};
  endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Synchronous pixel FIFO with flush; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module lcd_rx_fifo
  import lcd_rx_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = rx_pix_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_panel_rx.sv
// Panel-side LCD pin receiver: pixel capture, X/Y tagging, geometry and error flags.
// Optional frame signature enabled by defining LCD_RX_SIG_EN.
module lcd_panel_rx
  import lcd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int XW         = 11,
  parameter int YW         = 11
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          LCDPWR,
  input  logic          LCDFP,
  input  logic          LCDLP,
  input  logic          LCDENA_LCDM,
  input  logic          LCDDCLK,
  input  logic [23:0]   LCDVD,
  input  logic          ivs,
  input  logic          ihs,
  input  logic          clr,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [23:0]   px_data,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic          px_sof,
  output logic [XW-1:0] last_ppl,
  output logic [YW-1:0] last_lpp,
  output logic [15:0]   frame_cnt,
  output logic          frame_done,
  output logic          ovf_err,
  output logic          line_err,
  output logic [31:0]   frame_sig
);

  typedef struct packed {
    logic [23:0]   data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
  } pix_t;

  rx_state_t     state, state_d;
  logic          dclk_q, fp_q, lp_q, ena_q;
  logic          fp, lp, dclk_rise, fp_rise, lp_rise;
  logic [XW-1:0] x, x_inc, ref_ppl;
  logic [YW-1:0] y, y_inc;
  logic          sof_pend;
  logic          active, cap, eol, frame_end, frame_start;
  logic          pop, full, empty, ovf_hit, line_bad;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  pix_t          head, push_pix;
  logic          unused_sigs;

  assign fp        = LCDFP ^ ivs;
  assign lp        = LCDLP ^ ihs;
  assign dclk_rise = LCDDCLK & ~dclk_q;
  assign fp_rise   = fp & ~fp_q;
  assign lp_rise   = lp & ~lp_q;
  assign x_inc     = (&x) ? x : x + XW'(1);
  assign y_inc     = (&y) ? y : y + YW'(1);

  always_comb begin
    state_d = state;
    if (!LCDPWR) begin
      state_d = RX_OFF;
    end else begin
      case (state)
        RX_OFF:  state_d = RX_SYNC;
        RX_SYNC: if (fp_rise) state_d = RX_ACTIVE;
        default: state_d = state;
      endcase
    end
  end

  // A frame pulse with the line still open closes it in the same cycle; a
  // pixel strobe coinciding with the frame pulse is not captured.
  always_comb begin
    active      = LCDPWR & (state == RX_ACTIVE);
    frame_start = LCDPWR & fp_rise & (state != RX_OFF);
    frame_end   = active & fp_rise;
    cap         = active & dclk_rise & LCDENA_LCDM & ~fp_rise;
    eol         = active & ena_q & (fp_rise | (dclk_rise & ~LCDENA_LCDM));
    pop         = px_valid & px_ready;
    ovf_hit     = cap & full & ~pop;
    line_bad    = eol & (y != '0) & (x != ref_ppl);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= RX_OFF;
      dclk_q     <= 1'b0;
      fp_q       <= 1'b0;
      lp_q       <= 1'b0;
      ena_q      <= 1'b0;
      x          <= '0;
      y          <= '0;
      sof_pend   <= 1'b0;
      ref_ppl    <= '0;
      last_ppl   <= '0;
      last_lpp   <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      state      <= state_d;
      dclk_q     <= LCDDCLK;
      fp_q       <= fp;
      lp_q       <= lp;
      frame_done <= frame_end;

      if (!LCDPWR || fp_rise) ena_q <= 1'b0;
      else if (dclk_rise)     ena_q <= LCDENA_LCDM;

      if (!LCDPWR) begin
        x        <= '0;
        y        <= '0;
        sof_pend <= 1'b0;
      end else if (frame_start) begin
        x        <= '0;
        y        <= '0;
        sof_pend <= 1'b1;
      end else if (eol) begin
        x <= '0;
        y <= y_inc;
      end else if (cap) begin
        x        <= x_inc;
        sof_pend <= 1'b0;
      end

      if (eol) begin
        last_ppl <= x;
        if (y == '0) ref_ppl <= x;
      end

      if (frame_end) begin
        last_lpp  <= eol ? y_inc : y;
        frame_cnt <= frame_cnt + 16'd1;
      end

      ovf_err  <= ovf_hit  | (ovf_err  & ~clr);
      line_err <= line_bad | (line_err & ~clr);
    end
  end

  assign push_pix = '{data: LCDVD, x: x, y: y, sof: sof_pend};

  lcd_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pix_t)
  ) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .flush (~LCDPWR),
    .push  (cap),
    .pop   (pop),
    .din   (push_pix),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign px_valid = ~empty;
  assign px_data  = px_valid ? head.data : '0;
  assign px_x     = px_valid ? head.x    : '0;
  assign px_y     = px_valid ? head.y    : '0;
  assign px_sof   = px_valid & head.sof;

`ifdef LCD_RX_SIG_EN
  logic [31:0] sig, sig_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sig   <= '0;
      sig_q <= '0;
    end else if (frame_start) begin
      sig <= SIG_SEED;
      if (frame_end) sig_q <= sig;
    end else if (cap) begin
      sig <= sig_step(sig, LCDVD);
    end
  end

  assign frame_sig = sig_q;
`else
  assign frame_sig = '0;
`endif

  assign unused_sigs = &{1'b0, lp_rise, fifo_count};

endmodule

// File: tb/tb_lcd_panel_rx.sv
// Self-checking bench for lcd_panel_rx; frame-signature check active when LCD_RX_SIG_EN is defined.
module tb_lcd_panel_rx;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        LCDPWR, LCDFP, LCDLP, LCDENA_LCDM, LCDDCLK;
  logic [23:0] LCDVD;
  logic        ivs, ihs, clr, px_ready;
  logic        px_valid, px_sof, frame_done, ovf_err, line_err;
  logic [23:0] px_data;
  logic [10:0] px_x, last_ppl;
  logic [10:0] px_y, last_lpp;
  logic [15:0] frame_cnt;
  logic [31:0] frame_sig;

  lcd_panel_rx #(.FIFO_DEPTH(8), .XW(11), .YW(11)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .LCDPWR(LCDPWR), .LCDFP(LCDFP), .LCDLP(LCDLP),
    .LCDENA_LCDM(LCDENA_LCDM), .LCDDCLK(LCDDCLK), .LCDVD(LCDVD), .ivs(ivs), .ihs(ihs),
    .clr(clr), .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_x(px_x),
    .px_y(px_y), .px_sof(px_sof), .last_ppl(last_ppl), .last_lpp(last_lpp),
    .frame_cnt(frame_cnt), .frame_done(frame_done), .ovf_err(ovf_err),
    .line_err(line_err), .frame_sig(frame_sig)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [23:0] d;
    int          x;
    int          y;
    bit          sof;
  } exp_t;

  exp_t exp_q[$];
  exp_t em;
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;
  int   idx = 0;
  bit   data_mode = 1'b0;
  bit   cap_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output-side scoreboard: every accepted beat must be the oldest expected pixel.
  always @(negedge HCLK) begin
    if (frame_done === 1'b1) fd_count++;
    if (HRESETn === 1'b1 && px_valid === 1'b1 && px_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("px_unexpected", {63'd0, px_valid}, 64'd0);
      end else begin
        em = exp_q.pop_front();
        chk("px_data", px_data, em.d);
        chk("px_x", px_x, em.x);
        chk("px_y", px_y, em.y);
        chk("px_sof", px_sof, em.sof);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge HCLK);
      #1;
    end
  endtask

  function automatic logic [23:0] next_data();
    logic [23:0] d;
    if (data_mode == 1'b0) begin
      d = idx[23:0];
      idx++;
    end else begin
      d = $urandom;
    end
    return d;
  endfunction

  task automatic send_pix(input logic [23:0] d, input logic ena, input bit lat);
    LCDVD = d;
    LCDENA_LCDM = ena;
    if (lat) chk("latency_before", px_valid, 0);
    LCDDCLK = 1'b1;
    tick(1);
    if (lat) chk("latency_after", px_valid, 1);
    tick($urandom_range(0, 1));
    LCDDCLK = 1'b0;
    tick($urandom_range(1, 3));
  endtask

  task automatic send_line(input int n, input int yy, input bit close_it);
    logic [23:0] d;
    for (int p = 0; p < n; p++) begin
      d = next_data();
      if (cap_on) exp_q.push_back('{d: d, x: p, y: yy, sof: (p == 0 && yy == 0)});
      send_pix(d, 1'b1, 1'b0);
    end
    if (close_it) begin
      send_pix(24'h0, 1'b0, 1'b0);
      LCDLP = ~ihs;
      tick(1);
      LCDLP = ihs;
      tick(1);
    end
  endtask

  task automatic send_fp();
    LCDFP = ~ivs;
    tick(2);
    LCDFP = ivs;
    tick(2);
  endtask

  task automatic send_frame(input int nl);
    send_fp();
    for (int l = 0; l < nl; l++) send_line(16, l, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset(input logic iv, input logic ih);
    HRESETn = 1'b0;
    ivs = iv; ihs = ih;
    LCDPWR = 1'b0; LCDFP = iv; LCDLP = ih;
    LCDENA_LCDM = 1'b0; LCDDCLK = 1'b0; LCDVD = '0;
    clr = 1'b0; px_ready = 1'b1; cap_on = 1'b0;
    tick(2);
    chk("reset_flags", {px_valid, px_sof, frame_done, ovf_err, line_err, last_ppl, last_lpp, frame_cnt}, 0);
    chk("reset_px_data", px_data, 0);
    chk("reset_frame_sig", frame_sig, 0);
    HRESETn = 1'b1;
    tick(1);
  endtask

  task automatic power_on();
    LCDPWR = 1'b1;
    tick(3);
  endtask

  task automatic test_basic(input logic iv, input logic ih);
    int base;
    do_reset(iv, ih);
    power_on();
    data_mode = 1'b0; idx = 0; cap_on = 1'b1;
    base = fd_count;
    for (int f = 0; f < 3; f++) send_frame(4);
    drain();
    chk("basic_pixels_sent", idx, 192);
    chk("basic_frame_done", fd_count - base, 2);
    chk("basic_last_ppl", last_ppl, 16);
    chk("basic_last_lpp", last_lpp, 4);
    chk("basic_frame_cnt", frame_cnt, 2);
    chk("basic_errs", {ovf_err, line_err}, 0);
`ifndef LCD_RX_SIG_EN
    chk("sig_tied_off", frame_sig, 0);
`endif
  endtask

  initial begin
    int base;
    logic [23:0] d;
    logic [31:0] msig;

    // Nominal polarity, then inverted pins with inverted polarity selects.
    test_basic(1'b0, 1'b0);
    test_basic(1'b1, 1'b1);

    // Back-pressure: 8 pixels fill the FIFO, the 9th is dropped.
    do_reset(1'b0, 1'b0);
    px_ready = 1'b0;
    power_on();
    send_fp();
    for (int p = 0; p < 9; p++) begin
      d = $urandom;
      if (p < 8) exp_q.push_back('{d: d, x: p, y: 0, sof: (p == 0)});
      send_pix(d, 1'b1, p == 0);
      if (p == 7) chk("ovf_before_full", ovf_err, 0);
    end
    chk("ovf_set", ovf_err, 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("ovf_clr", ovf_err, 0);
    LCDVD = $urandom; LCDENA_LCDM = 1'b1; LCDDCLK = 1'b1; clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("ovf_clr_vs_new", ovf_err, 1);
    LCDDCLK = 1'b0; tick(2);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("ovf_clr2", ovf_err, 0);
    px_ready = 1'b1;
    drain();
    tick(2);
    chk("ovf_fifo_empty", px_valid, 0);

    // Short second line; then a frame whose last line is closed by the frame pulse.
    do_reset(1'b0, 1'b0);
    power_on();
    data_mode = 1'b1; cap_on = 1'b1;
    send_fp();
    send_line(16, 0, 1'b1);
    chk("line_err_ref", line_err, 0);
    send_line(15, 1, 1'b1);
    chk("line_err_set", line_err, 1);
    chk("short_last_ppl", last_ppl, 15);
    send_line(16, 2, 1'b1);
    send_line(16, 3, 1'b1);
    base = fd_count;
    send_fp();
    chk("short_frame_done", fd_count - base, 1);
    chk("short_last_lpp", last_lpp, 4);
    chk("line_err_sticky", line_err, 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("line_err_clr", line_err, 0);
    send_line(16, 0, 1'b1);
    send_line(16, 1, 1'b1);
    send_line(16, 2, 1'b0);
    send_fp();
    chk("open_line_lpp", last_lpp, 3);
    chk("open_line_ppl", last_ppl, 16);
    chk("open_line_cnt", frame_cnt, 2);
    drain();

    // Power drop at x=7 of line 1, junk pixels while off and during sync, then restore.
    do_reset(1'b0, 1'b0);
    power_on();
    data_mode = 1'b1; cap_on = 1'b1;
    send_fp();
    send_line(16, 0, 1'b1);
    send_line(7, 1, 1'b0);
    tick(2);
    base = fd_count;
    LCDPWR = 1'b0;
    cap_on = 1'b0;
    tick(2);
    for (int p = 0; p < 3; p++) send_pix($urandom, 1'b1, 1'b0);
    chk("pwr_off_empty", px_valid, 0);
    power_on();
    for (int p = 0; p < 3; p++) send_pix($urandom, 1'b1, 1'b0);
    cap_on = 1'b1;
    send_frame(4);
    chk("pwr_no_done_sync", fd_count - base, 0);
    send_frame(4);
    drain();
    chk("pwr_frame_done", fd_count - base, 1);
    chk("pwr_frame_cnt", frame_cnt, 1);
    chk("pwr_last_lpp", last_lpp, 4);

`ifdef LCD_RX_SIG_EN
    // 2x2 frame with data 1..4, signature folded from the seed.
    do_reset(1'b0, 1'b0);
    power_on();
    data_mode = 1'b0; idx = 1; cap_on = 1'b1;
    send_fp();
    send_line(2, 0, 1'b1);
    send_line(2, 1, 1'b1);
    send_fp();
    msig = 32'hFFFF_FFFF;
    for (int k = 1; k <= 4; k++) msig = ((msig << 1) | (msig >> 31)) ^ 32'(k);
    chk("frame_sig", frame_sig, msig);
    chk("sig_last_ppl", last_ppl, 2);
    chk("sig_last_lpp", last_lpp, 2);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
